// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller: state encoding and default sizes.
package nco_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_DWELL  = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEF_APR = 32;
  localparam int DEF_LAT = 12;
  localparam int DEF_DWW = 16;
  localparam int DEF_SIW = 16;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nco_sweep_step.sv
// Next-step adder for the sweep: cur + step in APR+1 bits, flags the final step.
module nco_sweep_step
  import nco_ctrl_pkg::*;
#(
  parameter int APR = DEF_APR
) (
  input  logic [APR-1:0] cur_i,
  input  logic [APR-1:0] step_i,
  input  logic [APR-1:0] stop_i,
  output logic [APR-1:0] nxt_o,
  output logic           last_o
);

  logic [APR:0] sum;

  assign sum    = {1'b0, cur_i} + {1'b0, step_i};
  assign nxt_o  = sum[APR-1:0];
  // A carry out must end the sweep rather than wrap to a low frequency.
  assign last_o = (step_i == '0) | sum[APR] | (sum[APR-1:0] > stop_i);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep sequencer for the sine NCO: steps phi_inc, waits out the NCO
// pipeline, then holds each step for a programmed number of valid samples.
//
//   state  | meaning
//   IDLE   | waiting for start, NCO clock gated off
//   SETTLE | new increment applied, waiting out the NCO pipeline
//   DWELL  | counting valid samples at the current increment
//   NEXT   | pick next increment, restart, or finish
//   DONE   | one-cycle completion pulse
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int APR = DEF_APR,
  parameter int DWW = DEF_DWW,
  parameter int LAT = DEF_LAT,
  parameter int SIW = DEF_SIW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic           repeat_en,
  input  logic [APR-1:0] f_start,
  input  logic [APR-1:0] f_stop,
  input  logic [APR-1:0] f_step,
  input  logic [DWW-1:0] dwell,
  input  logic           nco_valid,
  output logic [APR-1:0] phi_inc_o,
  output logic           nco_clken_o,
  output logic           busy,
  output logic           done,
  output logic           sample_valid,
  output logic           step_strobe,
  output logic [SIW-1:0] step_idx
);

  localparam int SCW = cnt_w(LAT);

  state_e         state_q;
  logic [APR-1:0] phi_q, f_start_q, f_stop_q, f_step_q;
  logic [DWW-1:0] dwell_q, dw_cnt_q;
  logic [SCW-1:0] settle_q;
  logic [SIW-1:0] idx_q;
  logic           rep_q, clken_q, busy_q, done_q, sv_q, strobe_q;

  logic [APR-1:0] nxt_d;
  logic           last_d;

  nco_sweep_step #(.APR(APR)) u_step (
    .cur_i  (phi_q),
    .step_i (f_step_q),
    .stop_i (f_stop_q),
    .nxt_o  (nxt_d),
    .last_o (last_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phi_q     <= '0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
      dw_cnt_q  <= '0;
      settle_q  <= '0;
      idx_q     <= '0;
      rep_q     <= 1'b0;
      clken_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sv_q      <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        clken_q <= 1'b0;
        sv_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              f_start_q <= f_start;
              f_stop_q  <= f_stop;
              f_step_q  <= f_step;
              rep_q     <= repeat_en;
              dwell_q   <= (dwell == '0) ? DWW'(1) : dwell;
              phi_q     <= f_start;
              idx_q     <= '0;
              strobe_q  <= 1'b1;
              busy_q    <= 1'b1;
              clken_q   <= 1'b1;
              settle_q  <= SCW'(LAT);
              dw_cnt_q  <= '0;
              state_q   <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            // The edge leaving SETTLE registers the first settled sample.
            if (settle_q == '0) begin
              sv_q     <= nco_valid;
              dw_cnt_q <= {{(DWW-1){1'b0}}, nco_valid};
              state_q  <= ST_DWELL;
            end else begin
              settle_q <= settle_q - SCW'(1);
            end
          end
          ST_DWELL: begin
            if (dw_cnt_q == dwell_q) begin
              sv_q    <= 1'b0;
              state_q <= ST_NEXT;
            end else begin
              sv_q <= nco_valid;
              if (nco_valid) dw_cnt_q <= dw_cnt_q + DWW'(1);
            end
          end
          ST_NEXT: begin
            if (!last_d || rep_q) begin
              phi_q    <= last_d ? f_start_q : nxt_d;
              idx_q    <= last_d ? '0 : idx_q + SIW'(1);
              strobe_q <= 1'b1;
              settle_q <= SCW'(LAT);
              dw_cnt_q <= '0;
              state_q  <= ST_SETTLE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            clken_q <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign phi_inc_o    = phi_q;
  assign nco_clken_o  = clken_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sv_q;
  assign step_strobe  = strobe_q;
  assign step_idx     = idx_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl with hand-computed sequences and cycle counts.
module tb_nco_sweep_ctrl;

  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        reset, start, abort, repeat_en, nco_valid;
  logic [31:0] f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [31:0] phi_inc_o;
  logic        nco_clken_o, busy, done, sample_valid, step_strobe;
  logic [15:0] step_idx;

  int n_tests = 0;
  int n_fail  = 0;

  int          n_strobe, n_sv, n_done, done_cyc, first_sv;
  logic [31:0] max_phi;
  logic [31:0] phis[$];
  logic [15:0] idxs[$];

  nco_sweep_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .repeat_en    (repeat_en),
    .f_start      (f_start),
    .f_stop       (f_stop),
    .f_step       (f_step),
    .dwell        (dwell),
    .nco_valid    (nco_valid),
    .phi_inc_o    (phi_inc_o),
    .nco_clken_o  (nco_clken_o),
    .busy         (busy),
    .done         (done),
    .sample_valid (sample_valid),
    .step_strobe  (step_strobe),
    .step_idx     (step_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulse sampled at the next edge; returns in the first SETTLE cycle (cycle 1).
  task automatic go(input logic [31:0] fs, input logic [31:0] fst, input logic [31:0] fp,
                    input logic [15:0] dw, input logic rep);
    f_start = fs; f_step = fst; f_stop = fp; dwell = dw; repeat_en = rep;
    n_strobe = 0; n_sv = 0; n_done = 0; done_cyc = 0; first_sv = 0; max_phi = '0;
    phis.delete(); idxs.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // vmode 0: nco_valid always 1, 1: valid on odd cycles. poke: cycle to re-pulse start.
  task automatic run(input int limit, input int vmode, input int poke);
    for (int c = 1; c <= limit; c++) begin
      if (step_strobe) begin
        n_strobe++;
        phis.push_back(phi_inc_o);
        idxs.push_back(step_idx);
      end
      if (sample_valid) begin
        n_sv++;
        if (first_sv == 0) first_sv = c;
      end
      if (phi_inc_o > max_phi) max_phi = phi_inc_o;
      if (done) begin
        n_done++;
        done_cyc = c;
      end
      if (!busy) break;
      start = (c == poke);
      if (c == poke) f_start = 32'd999;
      nco_valid = (vmode == 0) ? 1'b1 : ((c % 2) == 1);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int found;
    logic [31:0] hold;
    reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0; nco_valid = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    tick(); tick();
    chk("reset_outs", {phi_inc_o, nco_clken_o, busy, done, sample_valid, step_strobe, step_idx}, 64'd0);
    reset = 1'b0;
    tick();

    // Basic up-sweep
    go(32'd100, 32'd50, 32'd250, 16'd4, 1'b0);
    chk("up_busy", {busy, nco_clken_o, step_strobe}, 3'b111);
    run(200, 0, 0);
    chk("up_nstrobe", n_strobe, 4);
    chk("up_phi0", phis[0], 100);
    chk("up_phi1", phis[1], 150);
    chk("up_phi2", phis[2], 200);
    chk("up_phi3", phis[3], 250);
    chk("up_idx3", idxs[3], 3);
    chk("up_nsv", n_sv, 16);
    chk("up_ndone", n_done, 1);
    chk("up_done_cyc", done_cyc, 4 * (LAT + 1 + 4 + 1) + 1);
    chk("up_idle", {busy, nco_clken_o, phi_inc_o}, {2'b00, 32'd250});

    // Stop boundary: 12 must never be driven
    go(32'd0, 32'd3, 32'd10, 16'd1, 1'b0);
    run(200, 0, 0);
    chk("stop_nstrobe", n_strobe, 4);
    chk("stop_phi3", phis[3], 9);
    chk("stop_maxphi", max_phi, 9);
    chk("stop_ndone", n_done, 1);

    // Overflow terminates without wrapping
    go(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 16'd1, 1'b0);
    run(200, 0, 0);
    chk("ovf_nstrobe", n_strobe, 1);
    chk("ovf_phi", phi_inc_o, 32'hFFFF_FFF0);
    chk("ovf_ndone", n_done, 1);

    // Start above stop: one dwell at f_start
    go(32'd500, 32'd10, 32'd100, 16'd1, 1'b0);
    run(200, 0, 0);
    chk("inv_nstrobe", n_strobe, 1);
    chk("inv_ndone", n_done, 1);

    // Gapped valid, dwell 3, no SETTLE valids counted
    go(32'd40, 32'd0, 32'd100, 16'd3, 1'b0);
    run(200, 1, 0);
    chk("gap_nsv", n_sv, 3);
    chk("gap_first_sv", first_sv >= LAT + 2, 1'b1);
    chk("gap_ndone", n_done, 1);

    // dwell 0 as 1, f_step 0, start while busy ignored
    go(32'd5, 32'd0, 32'd100, 16'd0, 1'b0);
    run(200, 0, 5);
    chk("deg_nstrobe", n_strobe, 1);
    chk("deg_nsv", n_sv, 1);
    chk("deg_done_cyc", done_cyc, (LAT + 1 + 1 + 1) + 1);
    chk("deg_phi", phi_inc_o, 5);

    // Repeat: 10, 20, 10, 20 with index wrapping back to 0
    go(32'd10, 32'd10, 32'd20, 16'd2, 1'b1);
    run(70, 0, 0);
    chk("rep_nstrobe", n_strobe, 5);
    chk("rep_phis", {phis[0], phis[1]}, {32'd10, 32'd20});
    chk("rep_phis2", {phis[2], phis[3]}, {32'd10, 32'd20});
    chk("rep_idx", {idxs[0], idxs[1], idxs[2], idxs[3]}, {16'd0, 16'd1, 16'd0, 16'd1});

    // Abort while dwelling
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (sample_valid) found = 1;
      else tick();
    end
    chk("abort_reach_dwell", found, 1);
    hold = phi_inc_o;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outs", {busy, nco_clken_o, sample_valid, done}, 4'b0000);
    chk("abort_phi_hold", phi_inc_o, hold);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) n_done++;
      tick();
    end
    chk("abort_quiet", n_done, 0);

    // Reset mid-SETTLE
    go(32'd77, 32'd1, 32'd100, 16'd1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid", {phi_inc_o, nco_clken_o, busy, done, sample_valid, step_strobe, step_idx}, 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
